axil_csr_bridge: RTL
====================

// Module: axil_csr_bridge
// PURPOSE
//  Parametrised AXI4-Lite slave bridging PS register traffic onto a handshaked CSR bus.
//  Successor to the fixed single-cycle CSR slave; sits between the Zynq PS GP port and the CSR bank.
//  Adds byte strobes, 32/64-bit data, and address range decode (DECERR).
//  Adds backend wait states (csr_ack), ack timeout (SLVERR), read/write arbitration and an error counter.
// PARAMETERS
//  ADDR_WIDTH      8   byte address width
//  DATA_WIDTH      32  32 or 64; STRB_W = DATA_WIDTH/8, LSB = log2(STRB_W)
//  NUM_REGS        64  implemented words; word index = addr[ADDR_WIDTH-1:LSB]; legal iff index < NUM_REGS
//  TIMEOUT_CYCLES  16  max cycles csr_req may wait for csr_ack (>=1)
//  RD_PRIORITY     0   0: round-robin on R/W conflict; 1: read always wins
// PORTS
//  clk            in   1          clock
//  rst_n          in   1          async active-low reset
//  s_axi_aw*/w*/b*/ar*/r*  AXI4-Lite slave, DATA_WIDTH data, STRB_W wstrb; *prot ignored
//  csr_req        out  1          CSR access request, held until csr_ack or timeout
//  csr_we         out  1          1 write, 0 read
//  csr_addr       out  ADDR_WIDTH byte addr, low LSB bits forced 0
//  csr_wdata      out  DATA_WIDTH write data
//  csr_wstrb      out  STRB_W     byte enables; 0 on reads
//  csr_ack        in   1          backend done (same cycle as csr_req allowed)
//  csr_rdata      in   DATA_WIDTH read data, valid with csr_ack
//  csr_err        in   1          backend error, valid with csr_ack
//  err_count      out  16         saturating count of non-OKAY responses
// BEHAVIOUR
//  Reset: clk-independent; all valids/readys/csr_req 0, holding regs empty, resp 0, rdata 0, err_count 0, FSM IDLE.
//  Reset mid-transaction aborts it; no response is ever issued for it.
//  Capture: separate AW, W, AR holding regs.
//   awready = !aw_full; wready = !w_full; arready = !ar_full.
//   A handshake fills the reg next cycle; AW and W may arrive in any order or cycle.
//  FSM IDLE -> ISSUE -> RESP -> IDLE; one transaction in flight.
//   IDLE: write ready = aw_full & w_full; read ready = ar_full.
//   IDLE conflict: RD_PRIORITY=1 read wins; else the type not served last wins.
//   last_served resets to "write", so the first conflict after reset serves the read.
//   Leaving IDLE copies the chosen op into op regs and empties its holding reg(s), so the next request can be captured during ISSUE/RESP.
//  Decode: illegal index -> skip ISSUE, go to RESP with resp 2'b11 (DECERR), rdata 0, no csr_req.
//   Legal write with wstrb==0 -> RESP with OKAY, no csr_req.
//  ISSUE: csr_req=1; csr_we/addr/wdata/wstrb stable while csr_req=1.
//   csr_ack: latch csr_rdata (reads) and resp = csr_err ? 2'b10 : 2'b00; csr_req drops next cycle; -> RESP.
//   Timer counts cycles in ISSUE; at TIMEOUT_CYCLES with no ack -> drop csr_req, resp 2'b10, rdata 0, -> RESP.
//   csr_ack outside ISSUE is ignored.
//  RESP: bvalid (write) or rvalid (read) =1 with bresp/rresp/rdata held stable until the matching ready.
//   Handshake -> IDLE; next op may issue the following cycle.
//  Latency: zero-wait backend, AW+W in cycle 0 -> csr_req cycle 2 -> bvalid cycle 3.
//  err_count: +1 per non-OKAY response at the B/R handshake cycle; saturates at 16'hFFFF; cleared only by reset.
// TESTING
//  1. W(0xDEADBEEF, strb F) 3 cycles before AW(0x10) -> exactly one csr_req, we=1, addr 0x10; ack -> bresp 00.
//  2. AR 0x3C, csr_ack after 2 wait cycles, csr_rdata 0x12345678 -> rdata 0x12345678, rresp 00, csr_req high 3 cycles.
//  3. NUM_REGS=16, AR 0x40 -> no csr_req, rresp 11, rdata 0, err_count 1.
//  4. No ack, TIMEOUT_CYCLES=16 -> csr_req high exactly 16 cycles, then rresp 10, rdata 0.
//  5. RD_PRIORITY=0: AW+W and AR same cycle after reset -> read served first; repeat -> write first.
//     RD_PRIORITY=1 -> read always first.
//  6. bready low 10 cycles -> bvalid/bresp held; next AW/W captured, no csr_req until B handshake.
//     Assert rst_n low mid-ISSUE -> csr_req/bvalid 0 immediately, no stray response.

Source files
------------

// File: rtl/axil_csr_bridge.sv
// AXI4-Lite slave that turns PS register accesses into single, handshaked CSR bus cycles.
// It adds address decode, ack timeout, read/write arbitration and a saturating error counter.
module axil_csr_bridge #(
  parameter int ADDR_WIDTH     = 8,
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_REGS       = 64,
  parameter int TIMEOUT_CYCLES = 16,
  parameter int RD_PRIORITY    = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [2:0]              s_axi_awprot,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  output logic [1:0]              s_axi_bresp,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [2:0]              s_axi_arprot,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  output logic [DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]              s_axi_rresp,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready,
  output logic                    csr_req,
  output logic                    csr_we,
  output logic [ADDR_WIDTH-1:0]   csr_addr,
  output logic [DATA_WIDTH-1:0]   csr_wdata,
  output logic [DATA_WIDTH/8-1:0] csr_wstrb,
  input  logic                    csr_ack,
  input  logic [DATA_WIDTH-1:0]   csr_rdata,
  input  logic                    csr_err,
  output logic [15:0]             err_count,
  output logic [1:0]              dbg_state
);
  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int LSB    = $clog2(STRB_W);
  localparam int IDX_W  = ADDR_WIDTH - LSB;
  localparam int TW     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IDX_W:0] NREG = (IDX_W + 1)'(NUM_REGS);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ISSUE = 2'd1, S_RESP = 2'd2} state_t;
  state_t r_state, w_state_nx;

  logic              r_rdy_en;
  logic              r_aw_full, r_w_full, r_ar_full;
  logic [IDX_W-1:0]  r_aw_idx, r_ar_idx, r_op_idx;
  logic [DATA_WIDTH-1:0] r_w_data, r_op_wdata, r_rdata;
  logic [STRB_W-1:0] r_w_strb, r_op_wstrb;
  logic              r_op_we, r_last_wr;
  logic [1:0]        r_resp;
  logic [TW-1:0]     r_timer;
  logic [15:0]       r_err_cnt;

  logic             w_idle, w_wr_rdy, w_rd_rdy, w_pick_rd, w_pick_wr, w_legal, w_tmo, w_hs;
  logic [IDX_W-1:0] w_sel_idx;
  logic             w_unused;

  assign w_unused = ^{s_axi_awprot, s_axi_arprot, s_axi_awaddr[LSB-1:0], s_axi_araddr[LSB-1:0]};

  // Every channel transfers on a cycle where valid && ready are both high at the clock edge;
  // readys never depend on valids, and a raised valid holds its payload until accepted.
  assign w_idle    = (r_state == S_IDLE);
  assign w_wr_rdy  = r_aw_full & r_w_full;
  assign w_rd_rdy  = r_ar_full;
  assign w_pick_rd = w_idle & w_rd_rdy & (!w_wr_rdy | (RD_PRIORITY != 0) | r_last_wr);
  assign w_pick_wr = w_idle & w_wr_rdy & !w_pick_rd;
  assign w_sel_idx = w_pick_rd ? r_ar_idx : r_aw_idx;
  assign w_legal   = ({1'b0, w_sel_idx} < NREG);
  assign w_tmo     = (r_state == S_ISSUE) & !csr_ack & (r_timer == TW'(TIMEOUT_CYCLES - 1));
  assign w_hs      = (r_state == S_RESP) & (r_op_we ? s_axi_bready : s_axi_rready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE:  if (w_pick_rd || w_pick_wr)
                 w_state_nx = (!w_legal || (w_pick_wr && r_w_strb == '0)) ? S_RESP : S_ISSUE;
      S_ISSUE: if (csr_ack || w_tmo) w_state_nx = S_RESP;
      S_RESP:  if (w_hs) w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdy_en   <= 1'b0;
      r_aw_full  <= 1'b0;
      r_w_full   <= 1'b0;
      r_ar_full  <= 1'b0;
      r_aw_idx   <= '0;
      r_ar_idx   <= '0;
      r_w_data   <= '0;
      r_w_strb   <= '0;
      r_op_we    <= 1'b0;
      r_op_idx   <= '0;
      r_op_wdata <= '0;
      r_op_wstrb <= '0;
      r_last_wr  <= 1'b1;
      r_resp     <= 2'b00;
      r_rdata    <= '0;
      r_timer    <= '0;
      r_err_cnt  <= '0;
    end else begin
      r_rdy_en <= 1'b1;
      if (s_axi_awvalid && s_axi_awready) begin
        r_aw_full <= 1'b1;
        r_aw_idx  <= s_axi_awaddr[ADDR_WIDTH-1:LSB];
      end else if (w_pick_wr) r_aw_full <= 1'b0;
      if (s_axi_wvalid && s_axi_wready) begin
        r_w_full <= 1'b1;
        r_w_data <= s_axi_wdata;
        r_w_strb <= s_axi_wstrb;
      end else if (w_pick_wr) r_w_full <= 1'b0;
      if (s_axi_arvalid && s_axi_arready) begin
        r_ar_full <= 1'b1;
        r_ar_idx  <= s_axi_araddr[ADDR_WIDTH-1:LSB];
      end else if (w_pick_rd) r_ar_full <= 1'b0;
      // Launching an op frees its holding regs so the next request can queue behind it.
      if (w_pick_rd || w_pick_wr) begin
        r_op_we    <= w_pick_wr;
        r_op_idx   <= w_sel_idx;
        r_op_wdata <= w_pick_wr ? r_w_data : '0;
        r_op_wstrb <= w_pick_wr ? r_w_strb : '0;
        r_last_wr  <= w_pick_wr;
        r_timer    <= '0;
        r_rdata    <= '0;
        r_resp     <= w_legal ? 2'b00 : 2'b11;
      end
      if (r_state == S_ISSUE) begin
        if (csr_ack) begin
          r_resp <= csr_err ? 2'b10 : 2'b00;
          if (!r_op_we) r_rdata <= csr_rdata;
        end else if (w_tmo) begin
          r_resp  <= 2'b10;
          r_rdata <= '0;
        end else r_timer <= r_timer + 1'b1;
      end
      if (w_hs && r_resp != 2'b00 && r_err_cnt != 16'hFFFF) r_err_cnt <= r_err_cnt + 16'd1;
    end
  end

  assign s_axi_awready = r_rdy_en & !r_aw_full;
  assign s_axi_wready  = r_rdy_en & !r_w_full;
  assign s_axi_arready = r_rdy_en & !r_ar_full;
  assign s_axi_bvalid  = (r_state == S_RESP) & r_op_we;
  assign s_axi_bresp   = r_resp;
  assign s_axi_rvalid  = (r_state == S_RESP) & !r_op_we;
  assign s_axi_rresp   = r_resp;
  assign s_axi_rdata   = r_rdata;
  assign csr_req       = (r_state == S_ISSUE);
  assign csr_we        = r_op_we;
  assign csr_addr      = {r_op_idx, {LSB{1'b0}}};
  assign csr_wdata     = r_op_wdata;
  assign csr_wstrb     = r_op_wstrb;
  assign err_count     = r_err_cnt;
  assign dbg_state     = r_state;
endmodule
